// File: rtl/l1_cache_pkg.sv
// Shared types for the direct-mapped L1 cache: FSM state encoding and the
// offset/index/tag field widths of a 32-bit byte address.
package cache_types;

   localparam int XLEN     = 32;
   localparam int OFFSET_W = 5;
   localparam int INDEX_W  = 3;
   localparam int TAG_W    = XLEN - INDEX_W - OFFSET_W;
   localparam int WORD_W   = OFFSET_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FETCH     = 2'd2
   } cache_state_t;

   typedef logic [INDEX_W-1:0] index_t;
   typedef logic [TAG_W-1:0]   tag_t;
   typedef logic [WORD_W-1:0]  word_sel_t;

   function automatic logic [XLEN-1:0] line_addr(input tag_t tag, input index_t idx);
      return {tag, idx, {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/l1_cache_control.sv
// Miss-handling FSM for the L1 cache: sequences victim writeback and line fetch,
// and generates the registered pmem strobes plus the combinational hit response.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_IDLE      | serving hits; a non-stalled miss starts a line fill
//   ST_WRITEBACK | pmem_write high, pushing the dirty victim line out
//   ST_FETCH     | pmem_read high, waiting for the requested line
module l1_cache_control
   import cache_types::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic         mem_stall,
   input  logic         hit,
   input  logic         victim_dirty,
   input  logic         pmem_resp,
   output cache_state_t state,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic         mem_resp,
   output logic         mem_ready,
   output logic         start_miss,
   output logic         write_hit,
   output logic         clear_dirty,
   output logic         load_line
);

   cache_state_t state_q, state_d;
   logic         pmem_read_q, pmem_read_d;
   logic         pmem_write_q, pmem_write_d;
   logic         req;
   logic         idle;

   assign req  = mem_read | mem_write;
   assign idle = (state_q == ST_IDLE);

   always_comb begin
      state_d      = state_q;
      pmem_read_d  = pmem_read_q;
      pmem_write_d = pmem_write_q;
      start_miss   = 1'b0;
      clear_dirty  = 1'b0;
      load_line    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && !hit && !mem_stall) begin
               start_miss = 1'b1;
               if (victim_dirty) begin
                  state_d      = ST_WRITEBACK;
                  pmem_write_d = 1'b1;
               end else begin
                  state_d     = ST_FETCH;
                  pmem_read_d = 1'b1;
               end
            end
         end
         ST_WRITEBACK: begin
            if (pmem_resp) begin
               clear_dirty  = 1'b1;
               state_d      = ST_FETCH;
               pmem_write_d = 1'b0;
               pmem_read_d  = 1'b1;
            end
         end
         ST_FETCH: begin
            if (pmem_resp) begin
               load_line   = 1'b1;
               state_d     = ST_IDLE;
               pmem_read_d = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
      end
   end

   // Reset is folded in so the response outputs take their reset values
   // while rst_n is low, not just after the next edge.
   assign mem_resp  = ~rst_n | (idle & (~req | hit));
   assign mem_ready = rst_n & idle & mem_read & ~mem_write & hit;
   assign write_hit = rst_n & idle & mem_write & hit;

   assign state      = state_q;
   assign pmem_read  = pmem_read_q;
   assign pmem_write = pmem_write_q;

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache: tag/data/valid/dirty arrays
// and the hit datapath; miss sequencing lives in l1_cache_control.
module l1_cache
   import cache_types::*;
#(
   parameter int NUM_LINES = 8,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [31:0]          mem_address,
   input  logic [3:0]           mem_byte_enable,
   input  logic [31:0]          mem_wdata,
   input  logic                 mem_stall,
   output logic                 mem_resp,
   output logic                 mem_ready,
   output logic [31:0]          mem_rdata,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [31:0]          pmem_address,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
);

   logic [LINE_BITS-1:0] data_q [NUM_LINES];
   logic [LINE_BITS-1:0] data_d [NUM_LINES];
   tag_t                 tag_q  [NUM_LINES];
   tag_t                 tag_d  [NUM_LINES];
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   tag_t                 miss_tag_q, miss_tag_d;
   index_t               miss_idx_q, miss_idx_d;

   index_t       req_idx;
   tag_t         req_tag;
   word_sel_t    req_word;
   logic [7:0]   word_base;
   logic         hit;
   logic         victim_dirty;
   cache_state_t state;
   logic         start_miss, write_hit, clear_dirty, load_line;
   logic         unused_addr_lsb;

   assign req_idx         = mem_address[OFFSET_W +: INDEX_W];
   assign req_tag         = mem_address[XLEN-1 -: TAG_W];
   assign req_word        = mem_address[2 +: WORD_W];
   assign word_base       = {req_word, 5'b00000};
   assign unused_addr_lsb = ^mem_address[1:0];

   assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign victim_dirty = valid_q[req_idx] & dirty_q[req_idx];

   l1_cache_control u_control (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_stall    (mem_stall),
      .hit          (hit),
      .victim_dirty (victim_dirty),
      .pmem_resp    (pmem_resp),
      .state        (state),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .mem_resp     (mem_resp),
      .mem_ready    (mem_ready),
      .start_miss   (start_miss),
      .write_hit    (write_hit),
      .clear_dirty  (clear_dirty),
      .load_line    (load_line)
   );

   // The miss line is captured at miss start so a wandering mem_address
   // cannot redirect a fill already in flight.
   always_comb begin
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      tag_d      = tag_q;
      data_d     = data_q;
      miss_tag_d = miss_tag_q;
      miss_idx_d = miss_idx_q;
      if (start_miss) begin
         miss_tag_d = req_tag;
         miss_idx_d = req_idx;
      end
      if (write_hit) begin
         dirty_d[req_idx] = 1'b1;
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
               data_d[req_idx][{req_word, b[1:0], 3'b000} +: 8] = mem_wdata[b*8 +: 8];
            end
         end
      end
      if (clear_dirty) begin
         dirty_d[miss_idx_q] = 1'b0;
      end
      if (load_line) begin
         valid_d[miss_idx_q] = 1'b1;
         dirty_d[miss_idx_q] = 1'b0;
         tag_d[miss_idx_q]   = miss_tag_q;
         data_d[miss_idx_q]  = pmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         dirty_q    <= '0;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else begin
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         miss_tag_q <= miss_tag_d;
         miss_idx_q <= miss_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   always_comb begin
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state)
         ST_WRITEBACK: begin
            pmem_address = line_addr(tag_q[miss_idx_q], miss_idx_q);
            pmem_wdata   = data_q[miss_idx_q];
         end
         ST_FETCH: pmem_address = line_addr(miss_tag_q, miss_idx_q);
         default:  pmem_address = '0;
      endcase
   end

   assign mem_rdata = mem_ready ? data_q[req_idx][word_base +: 32] : 32'h0;

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: cold miss, hits, byte writes, dirty eviction,
// stall hold, ignored stray pmem_resp and reset during a fetch.
module tb_l1_cache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mem_read, mem_write, mem_stall;
   logic [31:0]  mem_address, mem_wdata;
   logic [3:0]   mem_byte_enable;
   logic         mem_resp, mem_ready;
   logic [31:0]  mem_rdata;
   logic         pmem_read, pmem_write, pmem_resp;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;

   int checks = 0;
   int errors = 0;

   logic [255:0] line_a, line_b, line_c, exp_wb;

   l1_cache #(.NUM_LINES(8), .LINE_BITS(256)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_stall       (mem_stall),
      .mem_resp        (mem_resp),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) chk("strobes_exclusive", {255'd0, !(pmem_read && pmem_write)}, 256'd1);
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         line_a[i*32 +: 32] = 32'hA000_0000 + i;
         line_b[i*32 +: 32] = 32'hB000_0000 + i;
         line_c[i*32 +: 32] = 32'hC000_0000 + i;
      end
      exp_wb = line_a;
      exp_wb[63:32] = 32'hA000_AB01;
      exp_wb[95:64] = 32'h5A00_0002;

      rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_stall = 1'b0;
      mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
      pmem_resp = 1'b0; pmem_rdata = '0;

      // reset values
      repeat (2) @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h104;
      #1;
      chk("rst_resp", mem_resp, 1);
      chk("rst_ready", mem_ready, 0);
      chk("rst_rdata", mem_rdata, 0);
      chk("rst_pread", pmem_read, 0);
      chk("rst_pwrite", pmem_write, 0);
      mem_read = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // cold read miss
      @(negedge clk); mem_read = 1'b1; mem_address = 32'h104; #1;
      chk("cold_resp_low", mem_resp, 0);
      chk("cold_rdata_zero", mem_rdata, 0);
      @(negedge clk); #1;
      chk("cold_pread", pmem_read, 1);
      chk("cold_paddr", pmem_address, 32'h100);
      chk("cold_resp_wait", mem_resp, 0);
      @(negedge clk); #1;
      chk("cold_pread_hold", pmem_read, 1);
      pmem_resp = 1'b1; pmem_rdata = line_a;
      chk("cold_resp_at_presp", mem_resp, 0);
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("cold_resp", mem_resp, 1);
      chk("cold_ready", mem_ready, 1);
      chk("cold_rdata", mem_rdata, 32'hA000_0001);
      chk("cold_pread_drop", pmem_read, 0);

      // read hits
      @(negedge clk); #1;
      chk("hit_resp", mem_resp, 1);
      chk("hit_ready", mem_ready, 1);
      chk("hit_rdata", mem_rdata, 32'hA000_0001);
      chk("hit_no_pread", pmem_read, 0);
      mem_address = 32'h108; #1;
      chk("hit_rdata_w2", mem_rdata, 32'hA000_0002);

      // byte writes (second one with read also high: treated as write)
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; mem_address = 32'h104;
      mem_byte_enable = 4'b0010; mem_wdata = 32'h0000_AB00; #1;
      chk("wr_resp", mem_resp, 1);
      chk("wr_ready", mem_ready, 0);
      chk("wr_rdata", mem_rdata, 0);
      @(negedge clk);
      mem_read = 1'b1; mem_address = 32'h108;
      mem_byte_enable = 4'b1000; mem_wdata = 32'h5A00_0000; #1;
      chk("rw_resp", mem_resp, 1);
      chk("rw_ready", mem_ready, 0);
      @(negedge clk);
      mem_write = 1'b0; mem_address = 32'h104; #1;
      chk("wr_readback1", mem_rdata, 32'hA000_AB01);
      mem_address = 32'h108; #1;
      chk("wr_readback2", mem_rdata, 32'h5A00_0002);

      // dirty eviction
      @(negedge clk); mem_address = 32'h204; #1;
      chk("ev_resp_low", mem_resp, 0);
      @(negedge clk); #1;
      chk("ev_pwrite", pmem_write, 1);
      chk("ev_pread_low", pmem_read, 0);
      chk("ev_wb_addr", pmem_address, 32'h100);
      chk("ev_wb_data", pmem_wdata, exp_wb);
      pmem_resp = 1'b1;
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("ev_pwrite_drop", pmem_write, 0);
      chk("ev_pread", pmem_read, 1);
      chk("ev_fetch_addr", pmem_address, 32'h200);
      chk("ev_resp_wait", mem_resp, 0);
      pmem_resp = 1'b1; pmem_rdata = line_b;
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("ev_resp", mem_resp, 1);
      chk("ev_rdata", mem_rdata, 32'hB000_0001);

      // refetch of the written-back line: victim is clean, so no writeback
      @(negedge clk); mem_address = 32'h104; #1;
      chk("ref_resp_low", mem_resp, 0);
      @(negedge clk); #1;
      chk("ref_pread", pmem_read, 1);
      chk("ref_no_pwrite", pmem_write, 0);
      chk("ref_addr", pmem_address, 32'h100);
      pmem_resp = 1'b1; pmem_rdata = exp_wb;
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("ref_rdata", mem_rdata, 32'hA000_AB01);

      // stall hold
      @(negedge clk); mem_address = 32'h3E4; mem_stall = 1'b1;
      repeat (5) begin
         #1;
         chk("stall_resp", mem_resp, 0);
         chk("stall_pread", pmem_read, 0);
         chk("stall_pwrite", pmem_write, 0);
         @(negedge clk);
      end
      mem_stall = 1'b0; #1;
      chk("unstall_pread_low", pmem_read, 0);
      @(negedge clk); #1;
      chk("unstall_pread", pmem_read, 1);
      chk("unstall_addr", pmem_address, 32'h3E0);
      pmem_resp = 1'b1; pmem_rdata = line_c;
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("unstall_rdata", mem_rdata, 32'hC000_0001);

      // stray pmem_resp in IDLE
      @(negedge clk); mem_read = 1'b0; pmem_resp = 1'b1; pmem_rdata = '1; #1;
      chk("stray_resp", mem_resp, 1);
      chk("stray_ready", mem_ready, 0);
      @(negedge clk); pmem_resp = 1'b0; mem_read = 1'b1; mem_address = 32'h104; #1;
      chk("stray_line0", mem_rdata, 32'hA000_AB01);
      mem_address = 32'h3E4; #1;
      chk("stray_line7", mem_rdata, 32'hC000_0001);

      // reset during FETCH
      @(negedge clk); mem_address = 32'h504; #1;
      chk("rf_resp_low", mem_resp, 0);
      @(negedge clk); #1;
      chk("rf_pread", pmem_read, 1);
      chk("rf_addr", pmem_address, 32'h500);
      rst_n = 1'b0; #1;
      chk("rf_pread_drop", pmem_read, 0);
      chk("rf_resp", mem_resp, 1);
      chk("rf_ready", mem_ready, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      chk("rf_miss_again", mem_resp, 0);
      @(negedge clk); #1;
      chk("rf_refetch", pmem_read, 1);
      chk("rf_refetch_addr", pmem_address, 32'h500);
      pmem_resp = 1'b1; pmem_rdata = line_b;
      @(negedge clk); pmem_resp = 1'b0; #1;
      chk("rf_rdata", mem_rdata, 32'hB000_0001);
      mem_read = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameters SHALL be: NUM_LINES, default 8, number of direct-mapped lines; LINE_BITS, default 256, line width in bits (32-byte line).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 mem_read  in  1  datapath read request, held until mem_resp.
REQ-006 mem_write  in  1  datapath write request, held until mem_resp.
REQ-007 mem_address  in  32  word-aligned byte address.
REQ-008 mem_byte_enable  in  4  write byte lanes.
REQ-009 mem_wdata  in  32  write data.
REQ-010 mem_stall  in  1  datapath stalled; new misses are not started.
REQ-011 mem_resp  out  1  high when the current request is complete, or when no request is pending.
REQ-012 mem_ready  out  1  mem_rdata valid.
REQ-013 mem_rdata  out  32  read word.
REQ-014 pmem_read / pmem_write  out  1 each  line fetch / line writeback strobes.
REQ-015 pmem_address  out  32  line-aligned address (bits [4:0] = 0).
REQ-016 pmem_wdata  out  LINE_BITS  victim line.
REQ-017 pmem_rdata  in  LINE_BITS  fetched line.
REQ-018 pmem_resp  in  1  one-cycle completion pulse for pmem_read or pmem_write.

Function
REQ-019 Address split SHALL be offset [4:0], index [7:5], tag [31:8].
REQ-020 Policy SHALL be write-back, write-allocate; each line SHALL hold valid, dirty, tag and data.
REQ-021 The FSM SHALL have three states: IDLE, WRITEBACK, FETCH.
REQ-022 In IDLE, a hit SHALL be resolved combinationally in the same cycle: mem_resp=1; on a read, mem_ready=1 and mem_rdata = the selected word.
REQ-023 A write hit SHALL update only the enabled bytes and set dirty at the next clock edge.
REQ-024 With no request in IDLE, mem_resp SHALL be 1 and mem_ready SHALL be 0.
REQ-025 Transitions out of IDLE on a miss with mem_stall=0:
- victim valid and dirty: go to WRITEBACK;
- otherwise: go to FETCH.
While the miss is being handled, mem_resp SHALL be 0.
REQ-026 A miss while mem_stall=1 SHALL keep the FSM in IDLE with mem_resp=0.
REQ-027 WRITEBACK SHALL drive pmem_write=1, pmem_address={victim tag, index, 5'b0} and pmem_wdata=victim data; on pmem_resp it SHALL go to FETCH and clear dirty.
REQ-028 FETCH SHALL drive pmem_read=1 and pmem_address={request tag, index, 5'b0}.
REQ-029 On pmem_resp in FETCH, the cache SHALL:
- write the line with valid=1, dirty=0 and the new tag;
- return to IDLE, where the request then hits.
REQ-030 Latency:
- clean miss: mem_resp SHALL rise exactly 1 cycle after the FETCH pmem_resp;
- dirty miss: mem_resp SHALL rise 1 cycle after the second pmem_resp.
REQ-031 pmem_read and pmem_write SHALL never be high simultaneously.
REQ-032 pmem_resp outside WRITEBACK/FETCH SHALL be ignored.
REQ-033 mem_read and mem_write both high SHALL be treated as a write.
REQ-034 A change of mem_address mid-miss is illegal; the cache SHALL complete the original line fill.
REQ-035 mem_rdata SHALL be 0 whenever mem_ready=0.

Reset
REQ-036 On rst_n low, the cache SHALL take the following values immediately, regardless of state:
- FSM: IDLE;
- all valid and dirty bits: 0;
- pmem_read, pmem_write: 0;
- mem_ready: 0; mem_rdata: 0;
- mem_resp: 1.
An in-progress miss SHALL be abandoned.
REQ-037 Tag and data arrays SHALL need no reset.

Structure
REQ-038 The FSM state enum and the offset/index/tag field widths SHALL live in a shared package, cache_types.
REQ-039 The block SHALL be split into one sub-module, l1_cache_control (FSM and strobe generation), plus datapath arrays in l1_cache.

Verification
REQ-040 Cold read: reset, then read 0x00000104 -> mem_resp=0; FETCH of 0x00000100; mem_resp=1 and mem_rdata = word 1 of the line, 1 cycle after pmem_resp.
REQ-041 Read hit: repeat read 0x00000104 -> mem_resp=1 and mem_ready=1 in the same cycle, with no pmem activity.
REQ-042 Byte write: write 0x00000104 with byte_enable=4'b0010, wdata=0x0000AB00 -> hit; a subsequent read returns the old word with byte 1 = 0xAB; line marked dirty.
REQ-043 Dirty eviction: read 0x00000204 (same index, new tag) ->
- WRITEBACK to 0x00000100 carrying the modified line;
- then FETCH of 0x00000200;
- pmem_read and pmem_write never both high.
REQ-044 Stall hold: a miss presented with mem_stall=1 for 5 cycles -> no pmem strobes, mem_resp=0; miss starts the cycle after mem_stall falls.
REQ-045 Reset mid-FETCH: assert rst_n=0 during FETCH -> pmem_read drops immediately; the next read of the same address misses again.
